// File: rtl/usb_desc_fetch.sv
// usb_desc_fetch: GET_DESCRIPTOR sequencer, ROM to EP0 IN with MPS packetization.
// Define USB_DESC_STR_EN to serve string descriptors (type 3).
module usb_desc_fetch #(
    parameter int MPS       = 64,
    parameter bit HSSUPPORT = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_req_valid,
    input  logic [7:0]  i_req_type,
    input  logic [7:0]  i_req_index,
    input  logic [15:0] i_req_wlength,
    input  logic        i_highspeed,
    input  logic        i_abort,
    input  logic [9:0]  i_desc_dev_addr,
    input  logic [9:0]  i_desc_qual_addr,
    input  logic [9:0]  i_desc_fscfg_addr,
    input  logic [9:0]  i_desc_hscfg_addr,
    input  logic [9:0]  i_desc_strlang_addr,
    input  logic [9:0]  i_desc_strvendor_addr,
    input  logic [9:0]  i_desc_strproduct_addr,
    input  logic [9:0]  i_desc_strserial_addr,
    input  logic [7:0]  i_desc_dev_len,
    input  logic [7:0]  i_desc_qual_len,
    input  logic [7:0]  i_desc_fscfg_len,
    input  logic [7:0]  i_desc_hscfg_len,
    input  logic [7:0]  i_desc_strvendor_len,
    input  logic [7:0]  i_desc_strproduct_len,
    input  logic [7:0]  i_desc_strserial_len,
    input  logic        i_descrom_have_strings,
    output logic [9:0]  o_descrom_raddr,
    input  logic [7:0]  i_descrom_rdat,
    output logic        o_txval,
    output logic [7:0]  o_txdat,
    input  logic        i_txpop,
    output logic        o_txpktend,
    output logic        o_zlp,
    input  logic        i_pkt_done,
    output logic        o_busy,
    output logic        o_stall
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, SEND, WAIT_ACK, ZLP, WAIT_ZLP, STALL
    } state_t;

    localparam logic [15:0] L_MASK = 16'(MPS - 1);
    localparam logic [6:0]  L_LAST = 7'(MPS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_type;
    logic [7:0]  r_index;
    logic [15:0] r_wlen;
    logic [15:0] r_total;
    logic [15:0] r_rem;
    logic [9:0]  r_ptr;
    logic [6:0]  r_pkt_cnt;

    logic        w_hit;
    logic [9:0]  w_base;
    logic [7:0]  w_len;
    logic [15:0] w_len16;
    logic [15:0] w_total;
    logic        w_go;
    logic        w_pktend;
    logic        w_latch;
    logic        w_need_zlp;

    always_comb begin
        w_hit  = 1'b0;
        w_base = '0;
        w_len  = '0;
        case (r_type)
            8'd1: begin
                w_hit  = 1'b1;
                w_base = i_desc_dev_addr;
                w_len  = i_desc_dev_len;
            end
            8'd2: begin
                w_hit  = 1'b1;
                w_base = i_highspeed ? i_desc_hscfg_addr : i_desc_fscfg_addr;
                w_len  = i_highspeed ? i_desc_hscfg_len : i_desc_fscfg_len;
            end
            8'd6: begin
                w_hit  = HSSUPPORT;
                w_base = i_desc_qual_addr;
                w_len  = i_desc_qual_len;
            end
            // Other-speed config: the descriptor of the speed we are not running at
            8'd7: begin
                w_hit  = HSSUPPORT;
                w_base = i_highspeed ? i_desc_fscfg_addr : i_desc_hscfg_addr;
                w_len  = i_highspeed ? i_desc_fscfg_len : i_desc_hscfg_len;
            end
`ifdef USB_DESC_STR_EN
            8'd3: begin
                case (r_index)
                    8'd0: begin
                        w_hit  = i_descrom_have_strings;
                        w_base = i_desc_strlang_addr;
                        w_len  = 8'd4;
                    end
                    8'd1: begin
                        w_hit  = i_descrom_have_strings;
                        w_base = i_desc_strvendor_addr;
                        w_len  = i_desc_strvendor_len;
                    end
                    8'd2: begin
                        w_hit  = i_descrom_have_strings;
                        w_base = i_desc_strproduct_addr;
                        w_len  = i_desc_strproduct_len;
                    end
                    8'd3: begin
                        w_hit  = i_descrom_have_strings;
                        w_base = i_desc_strserial_addr;
                        w_len  = i_desc_strserial_len;
                    end
                    default: ;
                endcase
            end
`endif
            default: ;
        endcase
    end

`ifndef USB_DESC_STR_EN
    logic w_unused;
    assign w_unused = ^{i_desc_strlang_addr, i_desc_strvendor_addr,
                        i_desc_strproduct_addr, i_desc_strserial_addr,
                        i_desc_strvendor_len, i_desc_strproduct_len,
                        i_desc_strserial_len, i_descrom_have_strings,
                        r_index};
`endif

    assign w_len16    = {8'd0, w_len};
    assign w_total    = (w_len16 < r_wlen) ? w_len16 : r_wlen;
    assign w_go       = w_hit && (w_len != 8'd0);
    assign w_pktend   = (r_pkt_cnt == L_LAST) || (r_rem == 16'd1);
    assign w_need_zlp = (r_total < r_wlen) && ((r_total & L_MASK) == 16'd0);
    assign w_latch    = i_req_valid && !i_abort &&
                        ((r_state == IDLE) || (r_state == STALL));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (i_req_valid) w_next = LOOKUP;
            LOOKUP: begin
                if (!w_go)                 w_next = STALL;
                else if (w_total == 16'd0) w_next = ZLP;
                else                       w_next = SEND;
            end
            SEND:     if (i_txpop && w_pktend) w_next = WAIT_ACK;
            WAIT_ACK: begin
                if (i_pkt_done) begin
                    if (r_rem != 16'd0) w_next = SEND;
                    else if (w_need_zlp) w_next = ZLP;
                    else                 w_next = IDLE;
                end
            end
            ZLP:      w_next = WAIT_ZLP;
            WAIT_ZLP: if (i_pkt_done) w_next = IDLE;
            STALL:    if (i_req_valid) w_next = LOOKUP;
            default:  w_next = IDLE;
        endcase
        if (i_abort) w_next = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_type    <= '0;
            r_index   <= '0;
            r_wlen    <= '0;
            r_total   <= '0;
            r_rem     <= '0;
            r_ptr     <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (i_abort) begin
                r_rem     <= '0;
                r_ptr     <= '0;
                r_pkt_cnt <= '0;
            end else begin
                if (w_latch) begin
                    r_type  <= i_req_type;
                    r_index <= i_req_index;
                    r_wlen  <= i_req_wlength;
                end
                if (r_state == LOOKUP) begin
                    r_ptr     <= w_base;
                    r_rem     <= w_total;
                    r_total   <= w_total;
                    r_pkt_cnt <= '0;
                end
                if ((r_state == SEND) && i_txpop) begin
                    r_ptr     <= r_ptr + 10'd1;
                    r_rem     <= r_rem - 16'd1;
                    r_pkt_cnt <= r_pkt_cnt + 7'd1;
                end
                if ((r_state == WAIT_ACK) && i_pkt_done) r_pkt_cnt <= '0;
            end
        end
    end

    assign o_descrom_raddr = r_ptr;
    assign o_txval         = (r_state == SEND);
    assign o_txdat         = i_descrom_rdat;
    assign o_txpktend      = (r_state == SEND) && w_pktend;
    assign o_zlp           = (r_state == ZLP);
    assign o_busy          = (r_state != IDLE) && (r_state != STALL);
    assign o_stall         = (r_state == STALL);

endmodule

// File: tb/tb_usb_desc_fetch.sv
// tb_usb_desc_fetch: directed scoreboard bench for usb_desc_fetch (MPS=16, no HS extras).
// Honors USB_DESC_STR_EN for the string-descriptor expectations.
module tb_usb_desc_fetch;

    localparam int MPS = 16;
    localparam logic [9:0] A_DEV  = 10'h000;
    localparam logic [9:0] A_QUAL = 10'h020;
    localparam logic [9:0] A_FS   = 10'h040;
    localparam logic [9:0] A_HS   = 10'h080;
    localparam logic [9:0] A_LANG = 10'h3F0;
    localparam logic [9:0] A_VEN  = 10'h100;
    localparam logic [9:0] A_PRD  = 10'h110;
    localparam logic [9:0] A_SER  = 10'h120;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        i_req_valid;
    logic [7:0]  i_req_type;
    logic [7:0]  i_req_index;
    logic [15:0] i_req_wlength;
    logic        i_highspeed;
    logic        i_abort;
    logic [9:0]  o_descrom_raddr;
    logic [7:0]  i_descrom_rdat;
    logic        o_txval;
    logic [7:0]  o_txdat;
    logic        i_txpop;
    logic        o_txpktend;
    logic        o_zlp;
    logic        i_pkt_done;
    logic        o_busy;
    logic        o_stall;

    logic [7:0]  rom [0:1023];
    logic [8:0]  exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    assign i_descrom_rdat = rom[o_descrom_raddr];

    always #5 CLK = ~CLK;

    usb_desc_fetch #(.MPS(MPS), .HSSUPPORT(1'b0)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_req_valid(i_req_valid), .i_req_type(i_req_type),
        .i_req_index(i_req_index), .i_req_wlength(i_req_wlength),
        .i_highspeed(i_highspeed), .i_abort(i_abort),
        .i_desc_dev_addr(A_DEV), .i_desc_qual_addr(A_QUAL),
        .i_desc_fscfg_addr(A_FS), .i_desc_hscfg_addr(A_HS),
        .i_desc_strlang_addr(A_LANG), .i_desc_strvendor_addr(A_VEN),
        .i_desc_strproduct_addr(A_PRD), .i_desc_strserial_addr(A_SER),
        .i_desc_dev_len(8'd18), .i_desc_qual_len(8'd10),
        .i_desc_fscfg_len(8'd32), .i_desc_hscfg_len(8'd32),
        .i_desc_strvendor_len(8'd6), .i_desc_strproduct_len(8'd8),
        .i_desc_strserial_len(8'd0), .i_descrom_have_strings(1'b1),
        .o_descrom_raddr(o_descrom_raddr), .i_descrom_rdat(i_descrom_rdat),
        .o_txval(o_txval), .o_txdat(o_txdat), .i_txpop(i_txpop),
        .o_txpktend(o_txpktend), .o_zlp(o_zlp), .i_pkt_done(i_pkt_done),
        .o_busy(o_busy), .o_stall(o_stall)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [7:0] t, input logic [7:0] idx,
                       input logic [15:0] wl);
        @(negedge CLK);
        i_req_valid   = 1'b1;
        i_req_type    = t;
        i_req_index   = idx;
        i_req_wlength = wl;
        @(negedge CLK);
        i_req_valid   = 1'b0;
    endtask

    task automatic push_exp(input logic [9:0] base, input int total);
        for (int i = 0; i < total; i++) begin
            logic pe;
            pe = ((i % MPS) == MPS - 1) || (i == total - 1);
            exp_q.push_back({pe, rom[10'(base + 10'(i))]});
        end
    endtask

    task automatic serve(input int exp_zlp, input bit tog, input bit first_now);
        int zlps = 0;
        bit ack = 0;
        bit done = 0;
        bit hold = 0;
        logic [7:0] hdat = '0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge CLK);
            i_pkt_done = 1'b0;
            if (ack) begin
                i_pkt_done = 1'b1;
                ack = 0;
            end
            if (cyc == 0 && first_now) check("first_txval", o_txval, 1);
            if (hold) begin
                check("hold_val", o_txval, 1);
                check("hold_dat", o_txdat, hdat);
                hold = 0;
            end
            i_txpop = tog ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_zlp) begin
                zlps++;
                ack = 1;
            end
            if (o_txval) begin
                if (i_txpop) begin
                    logic [8:0] e;
                    e = 'x;
                    if (exp_q.size() > 0) e = exp_q.pop_front();
                    check("byte", {o_txpktend, o_txdat}, e);
                    if (o_txpktend) ack = 1;
                end else begin
                    hold = 1;
                    hdat = o_txdat;
                end
            end else if (!o_busy && !i_pkt_done && !ack &&
                         exp_q.size() == 0 && cyc > 0) begin
                done = 1;
            end
        end
        i_txpop    = 1'b0;
        i_pkt_done = 1'b0;
        check("xfer_done", done, 1);
        check("zlp_count", zlps, exp_zlp);
        check("q_empty", exp_q.size(), 0);
    endtask

    task automatic stall_chk(input logic [7:0] t, input logic [7:0] idx);
        req(t, idx, 16'd64);
        check("stall_early", o_stall, 0);
        @(negedge CLK);
        check("stall", o_stall, 1);
        check("stall_txval", o_txval, 0);
        check("stall_busy", o_busy, 0);
        @(negedge CLK);
        check("stall_hold", o_stall, 1);
        i_abort = 1'b1;
        @(negedge CLK);
        i_abort = 1'b0;
        check("stall_clr", o_stall, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i * 7 + 3);
        rom[0] = 8'h12; rom[1] = 8'h01; rom[2] = 8'h00; rom[3] = 8'h02;
        rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'h40;
        rom[A_LANG]       = 8'h04;
        rom[A_LANG + 10'd1] = 8'h03;
        rom[A_LANG + 10'd2] = 8'h09;
        rom[A_LANG + 10'd3] = 8'h04;

        RESET = 1'b1; i_req_valid = 1'b0; i_req_type = '0;
        i_req_index = '0; i_req_wlength = '0; i_highspeed = 1'b0;
        i_abort = 1'b0; i_txpop = 1'b0; i_pkt_done = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_raddr", o_descrom_raddr, 0);
        check("rst_txval", o_txval, 0);
        check("rst_pktend", o_txpktend, 0);
        check("rst_zlp", o_zlp, 0);
        check("rst_busy", o_busy, 0);
        check("rst_stall", o_stall, 0);
        RESET = 1'b0;

        // device, wLength 64: 16 + 2 bytes, no ZLP
        req(8'd1, 8'd0, 16'd64);
        push_exp(A_DEV, 18);
        serve(0, 0, 1);

        // device, wLength 8: clamped
        req(8'd1, 8'd0, 16'd8);
        push_exp(A_DEV, 8);
        serve(0, 1, 1);

        // HS config 32 bytes, wLength 255: two full packets then ZLP
        i_highspeed = 1'b1;
        req(8'd2, 8'd0, 16'h00FF);
        push_exp(A_HS, 32);
        serve(1, 0, 1);

        req(8'd2, 8'd0, 16'd32);
        push_exp(A_HS, 32);
        serve(0, 1, 1);

        // FS config clamped to exactly one packet equal to wLength
        i_highspeed = 1'b0;
        req(8'd2, 8'd0, 16'd16);
        push_exp(A_FS, 16);
        serve(0, 0, 1);

        // wLength 0: straight to ZLP
        req(8'd1, 8'd0, 16'd0);
        serve(1, 0, 0);

        stall_chk(8'd3, 8'd5);
        stall_chk(8'd6, 8'd0);
        i_highspeed = 1'b1;
        stall_chk(8'd7, 8'd0);
        stall_chk(8'd9, 8'd0);

        // new request straight out of STALL
        req(8'd6, 8'd0, 16'd64);
        @(negedge CLK);
        check("stall2", o_stall, 1);
        req(8'd1, 8'd0, 16'd8);
        push_exp(A_DEV, 8);
        serve(0, 0, 1);

        // abort mid-transfer after five pops
        req(8'd2, 8'd0, 16'h00FF);
        push_exp(A_HS, 32);
        cnt = 0;
        for (int cyc = 0; cyc < 200 && cnt < 5; cyc++) begin
            @(negedge CLK);
            i_txpop = 1'($urandom_range(0, 1));
            if (o_txval && i_txpop) begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("abort_byte", {o_txpktend, o_txdat}, e);
                cnt++;
            end
        end
        check("abort_pops", cnt, 5);
        @(negedge CLK);
        i_txpop = 1'b0;
        i_abort = 1'b1;
        @(negedge CLK);
        i_abort = 1'b0;
        check("abort_txval", o_txval, 0);
        check("abort_busy", o_busy, 0);
        exp_q.delete();
        req(8'd2, 8'd0, 16'd32);
        push_exp(A_HS, 32);
        serve(0, 1, 1);

`ifdef USB_DESC_STR_EN
        req(8'd3, 8'd0, 16'h00FF);
        push_exp(A_LANG, 4);
        serve(0, 0, 1);
        req(8'd3, 8'd2, 16'd4);
        push_exp(A_PRD, 4);
        serve(0, 1, 1);
        stall_chk(8'd3, 8'd3);
`else
        stall_chk(8'd3, 8'd0);
`endif

        // pkt_done while idle is ignored
        @(negedge CLK);
        i_pkt_done = 1'b1;
        @(negedge CLK);
        i_pkt_done = 1'b0;
        check("idle_done_busy", o_busy, 0);
        check("idle_done_zlp", o_zlp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
